// File: rtl/vector_pkg.sv
// Shared vector datapath definitions: lane count, lane width and the word/address types
// used by the register file, operand mux and execute stages.
package vector_pkg;

    localparam int VLANES = 4;
    localparam int VWIDTH = 32;
    localparam int VAW    = 4;

    typedef logic [VWIDTH-1:0] vword_t;
    typedef logic [VAW-1:0]    vaddr_t;

    // Replicates one byte into every byte of a lane word.
    function automatic vword_t splat_byte(input logic [7:0] b);
        return {4{b}};
    endfunction

endpackage

// File: rtl/vector_regfile_if.sv
// Read/write bus of the vector register file; the master drives addresses and writeback,
// the slave (the register file) returns both read ports.
interface vector_regfile_if #(
    parameter int AW    = 4,
    parameter int WIDTH = 32
);

    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic             we;
    logic [AW-1:0]    wa;
    logic [3:0]       wmask;
    logic [WIDTH-1:0] wd1, wd2, wd3, wd4;
    logic [WIDTH-1:0] rd11, rd12, rd13, rd14;
    logic [WIDTH-1:0] rd21, rd22, rd23, rd24;

    modport master (
        output ra1, ra2, we, wa, wmask, wd1, wd2, wd3, wd4,
        input  rd11, rd12, rd13, rd14, rd21, rd22, rd23, rd24
    );

    modport slave (
        input  ra1, ra2, we, wa, wmask, wd1, wd2, wd3, wd4,
        output rd11, rd12, rd13, rd14, rd21, rd22, rd23, rd24
    );

endinterface

// File: rtl/vreg_lane.sv
// One lane of the vector register file: NREGS words of storage, one synchronous write
// port and two combinational read ports with write-first bypass.
module vreg_lane #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] mem [NREGS];
    logic             byp1;
    logic             byp2;

    // Reset wins over a write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                mem[r] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    // The bypass mux sits after the storage read mux; no forwarding while reset is asserted.
    assign byp1 = we && !rst && (ra1 == wa);
    assign byp2 = we && !rst && (ra2 == wa);
    assign rd1  = byp1 ? wd : mem[ra1];
    assign rd2  = byp2 ? wd : mem[ra2];

endmodule

// File: rtl/vector_regfile.sv
// Vector register file: NREGS registers of four lanes, built from one vreg_lane per lane
// whose write enable is qualified by that lane's wmask bit.
module vector_regfile
    import vector_pkg::*;
#(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    vector_regfile_if.slave  bus
);

    logic [WIDTH-1:0] wd  [VLANES];
    logic [WIDTH-1:0] rd1 [VLANES];
    logic [WIDTH-1:0] rd2 [VLANES];

    assign wd[0] = bus.wd1;
    assign wd[1] = bus.wd2;
    assign wd[2] = bus.wd3;
    assign wd[3] = bus.wd4;

    assign bus.rd11 = rd1[0];
    assign bus.rd12 = rd1[1];
    assign bus.rd13 = rd1[2];
    assign bus.rd14 = rd1[3];
    assign bus.rd21 = rd2[0];
    assign bus.rd22 = rd2[1];
    assign bus.rd23 = rd2[2];
    assign bus.rd24 = rd2[3];

    for (genvar i = 0; i < VLANES; i++) begin : g_lane
        vreg_lane #(
            .NREGS (NREGS),
            .AW    (AW),
            .WIDTH (WIDTH)
        ) u_lane (
            .clk (clk),
            .rst (rst),
            .we  (bus.we & bus.wmask[i]),
            .wa  (bus.wa),
            .wd  (wd[i]),
            .ra1 (bus.ra1),
            .ra2 (bus.ra2),
            .rd1 (rd1[i]),
            .rd2 (rd2[i])
        );
    end

endmodule

// File: tb/tb_vector_regfile.sv
// Self-checking bench for vector_regfile: directed scenarios plus a randomized run
// compared against an array model of the register contents.
module tb_vector_regfile;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic [31:0] model [16][4];
    logic [31:0] rd1 [4];
    logic [31:0] rd2 [4];

    vector_regfile_if #(.AW(4), .WIDTH(32)) bus ();

    vector_regfile #(.NREGS(16), .AW(4), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd1[0] = bus.rd11;
    assign rd1[1] = bus.rd12;
    assign rd1[2] = bus.rd13;
    assign rd1[3] = bus.rd14;
    assign rd2[0] = bus.rd21;
    assign rd2[1] = bus.rd22;
    assign rd2[2] = bus.rd23;
    assign rd2[3] = bus.rd24;

    function automatic logic [31:0] wd_lane(input int l);
        case (l)
            0:       return bus.wd1;
            1:       return bus.wd2;
            2:       return bus.wd3;
            default: return bus.wd4;
        endcase
    endfunction

    // Expected read value: the written word wins for an enabled lane at the same address.
    function automatic logic [31:0] exp_lane(input logic [3:0] a, input int l);
        if (bus.we && !rst && (a == bus.wa) && bus.wmask[l])
            return wd_lane(l);
        return model[a][l];
    endfunction

    task automatic drive(input logic w, input logic [3:0] waddr, input logic [3:0] mask,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        bus.we    = w;
        bus.wa    = waddr;
        bus.wmask = mask;
        bus.wd1   = d0;
        bus.wd2   = d1;
        bus.wd3   = d2;
        bus.wd4   = d3;
    endtask

    // Advances one clock edge, updates the model from the held inputs, returns at negedge.
    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 16; r++)
                for (int l = 0; l < 4; l++)
                    model[r][l] = '0;
        end else if (bus.we) begin
            for (int l = 0; l < 4; l++)
                if (bus.wmask[l]) model[bus.wa][l] = wd_lane(l);
        end
        @(negedge clk);
        bus.we = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic write_reg(input logic [3:0] waddr, input logic [3:0] mask,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2, input logic [31:0] d3);
        drive(1'b1, waddr, mask, d0, d1, d2, d3);
        cycle();
    endtask

    task automatic test_reset();
        logic [31:0] req [4];
        write_reg(4'd3, 4'b1111, 32'd1, 32'd2, 32'd3, 32'd4);
        bus.ra1 = 4'd3;
        #1;
        req = '{32'd1, 32'd2, 32'd3, 32'd4};
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== req[l]) begin
                fails++;
                $display("[TB] FAIL preload lane %0d: got %h expected %h", l, rd1[l], req[l]);
            end
        end
        rst = 1'b1;
        cycle();
        bus.ra1 = 4'd3;
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== 32'd0) begin
                fails++;
                $display("[TB] FAIL reset_clear lane %0d: got %h expected 0", l, rd1[l]);
            end
        end
    endtask

    task automatic test_full_write();
        logic [31:0] req [4];
        req = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        write_reg(4'd5, 4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        bus.ra1 = 4'd5;
        bus.ra2 = 4'd5;
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== req[l] || rd2[l] !== req[l]) begin
                fails++;
                $display("[TB] FAIL full_write lane %0d: got %h/%h expected %h", l, rd1[l], rd2[l], req[l]);
            end
        end
    endtask

    task automatic test_masked_write();
        logic [31:0] req [4];
        req = '{32'hB0, 32'hA1, 32'hB2, 32'hA3};
        write_reg(4'd5, 4'b0101, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        write_reg(4'd5, 4'b0000, 32'hEE, 32'hEE, 32'hEE, 32'hEE);
        bus.ra1 = 4'd5;
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== req[l]) begin
                fails++;
                $display("[TB] FAIL masked_write lane %0d: got %h expected %h", l, rd1[l], req[l]);
            end
        end
    endtask

    task automatic test_bypass();
        logic [31:0] c [4];
        logic [31:0] r6 [4];
        logic [31:0] m [4];
        c  = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
        r6 = '{32'h61, 32'h62, 32'h63, 32'h64};
        m  = '{32'h0, 32'hC1, 32'h0, 32'h0};
        write_reg(4'd6, 4'b1111, 32'h61, 32'h62, 32'h63, 32'h64);
        drive(1'b1, 4'd7, 4'b1111, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        bus.ra1 = 4'd7;
        bus.ra2 = 4'd6;
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== c[l] || rd2[l] !== r6[l]) begin
                fails++;
                $display("[TB] FAIL bypass_full lane %0d: got %h/%h expected %h/%h", l, rd1[l], rd2[l], c[l], r6[l]);
            end
        end
        cycle();
        drive(1'b1, 4'd8, 4'b0010, 32'hC0, 32'hC1, 32'hC2, 32'hC3);
        bus.ra1 = 4'd8;
        bus.ra2 = 4'd8;
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== m[l] || rd2[l] !== m[l]) begin
                fails++;
                $display("[TB] FAIL bypass_masked lane %0d: got %h/%h expected %h", l, rd1[l], rd2[l], m[l]);
            end
        end
        cycle();
    endtask

    task automatic test_reset_priority();
        write_reg(4'd2, 4'b1111, 32'hE0, 32'hE1, 32'hE2, 32'hE3);
        rst = 1'b1;
        drive(1'b1, 4'd2, 4'b1111, 32'hD0, 32'hD1, 32'hD2, 32'hD3);
        bus.ra1 = 4'd2;
        bus.ra2 = 4'd2;
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== (32'hE0 + l) || rd2[l] !== (32'hE0 + l)) begin
                fails++;
                $display("[TB] FAIL rst_no_bypass lane %0d: got %h/%h expected %h", l, rd1[l], rd2[l], 32'hE0 + l);
            end
        end
        cycle();
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== 32'd0) begin
                fails++;
                $display("[TB] FAIL rst_priority lane %0d: got %h expected 0", l, rd1[l]);
            end
        end
    endtask

    task automatic test_dual_port();
        write_reg(4'd1, 4'b1111, 32'h1, 32'h1, 32'h1, 32'h1);
        write_reg(4'd15, 4'b1111, 32'hF, 32'hF, 32'hF, 32'hF);
        bus.ra1 = 4'd1;
        bus.ra2 = 4'd15;
        #1;
        for (int l = 0; l < 4; l++) begin
            tests++;
            if (rd1[l] !== 32'h1 || rd2[l] !== 32'hF) begin
                fails++;
                $display("[TB] FAIL dual_port lane %0d: got %h/%h expected 1/f", l, rd1[l], rd2[l]);
            end
        end
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 16; a++)
            write_reg(4'(a), 4'b1111, a * 32'h01010101, a * 32'h01010101 + 1,
                      a * 32'h01010101 + 2, a * 32'h01010101 + 3);
        for (int a = 0; a < 16; a++) begin
            bus.ra1 = 4'(a);
            bus.ra2 = 4'(15 - a);
            #1;
            for (int l = 0; l < 4; l++) begin
                tests++;
                if (rd1[l] !== (a * 32'h01010101 + l) || rd2[l] !== ((15 - a) * 32'h01010101 + l)) begin
                    fails++;
                    $display("[TB] FAIL sweep addr %0d lane %0d: got %h/%h expected %h/%h", a, l,
                             rd1[l], rd2[l], a * 32'h01010101 + l, (15 - a) * 32'h01010101 + l);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(31) == 0);
            drive($urandom_range(3) != 0, 4'($urandom_range(15)), 4'($urandom_range(15)),
                  $urandom, $urandom, $urandom, $urandom);
            bus.ra1 = ($urandom_range(3) == 0) ? bus.wa : 4'($urandom_range(15));
            bus.ra2 = ($urandom_range(3) == 0) ? bus.ra1 : 4'($urandom_range(15));
            #1;
            for (int l = 0; l < 4; l++) begin
                tests++;
                if (rd1[l] !== exp_lane(bus.ra1, l) || rd2[l] !== exp_lane(bus.ra2, l)) begin
                    fails++;
                    $display("[TB] FAIL random cycle %0d lane %0d: got %h/%h expected %h/%h", n, l,
                             rd1[l], rd2[l], exp_lane(bus.ra1, l), exp_lane(bus.ra2, l));
                end
            end
            cycle();
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int r = 0; r < 16; r++)
            for (int l = 0; l < 4; l++)
                model[r][l] = '0;
        bus.ra1 = '0;
        bus.ra2 = '0;
        drive(1'b0, 4'd0, 4'b0000, '0, '0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        cycle();
        test_reset();
        test_full_write();
        test_masked_write();
        test_bypass();
        test_reset_priority();
        test_dual_port();
        test_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vector_regfile.md
Name: vector_regfile

Overview:
- Vector register file of the ASIP vector datapath; directly upstream of the vector operand multiplexer.
- Holds NREGS vector registers, each 4 lanes x 32 bits.
- Two combinational read ports supply the operand-mux input groups; one synchronous write port with per-lane mask receives writeback.
- Write-first bypass: an instruction reading a register in the cycle it is written sees the new data.

Parameters:
- NREGS, 16, number of vector registers; must be a power of two, >= 2
- AW, 4, address width; must equal log2(NREGS)
- WIDTH, 32, lane width in bits

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ra1  in  AW  read address, port 1
- ra2  in  AW  read address, port 2
- we  in  1  write enable
- wa  in  AW  write address
- wmask  in  4  per-lane write enable; bit i selects lane i+1
- wd1, wd2, wd3, wd4  in  WIDTH each  write data, lanes 1-4
- rd11, rd12, rd13, rd14  out  WIDTH each  port-1 read data, lanes 1-4; feed the operand-mux group-1 inputs
- rd21, rd22, rd23, rd24  out  WIDTH each  port-2 read data, lanes 1-4; feed the operand-mux group-2 inputs

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - At a rising edge with rst=1, every lane of every register is cleared to 0.
  - rst has priority over we: a write presented in the reset cycle is discarded.
  - Outputs are combinational from storage, so they read 0 from the cycle after the reset edge.
  - Reset asserted between writes cancels nothing already committed; it simply clears everything.
- Write:
  - At a rising edge with rst=0 and we=1, lane i of register wa takes wd(i+1) only where wmask[i]=1.
  - Lanes with wmask[i]=0 keep their value.
  - we=1 with wmask=0 is a legal no-op.
- Read:
  - Purely combinational; zero latency.
  - rdPL = lane L of register raP.
  - No register is hardwired; register 0 is an ordinary register.
- Bypass (write-first):
  - Applies when we=1, rst=0 and raP==wa in the same cycle.
  - For every lane with wmask[i]=1, port P outputs the incoming wd(i+1) instead of the stored value.
  - Unmasked lanes output the stored value.
  - Bypass is per port and per lane; both ports may bypass simultaneously, including when ra1==ra2==wa.
  - No bypass while rst=1: outputs show stored contents until the reset edge takes effect.
- Same-address reads: ra1==ra2 returns identical data on both ports.
- Timing: no combinational path from any read output back to an input; the bypass path is a 2:1 mux per lane after the storage read mux.
- Widths: addresses are never out of range because NREGS = 2^AW; no wrap handling is required.

Decomposition:
- Shared package vector_pkg:
  - constants VLANES=4 and VWIDTH=32
  - typedef vword_t = logic [VWIDTH-1:0]
  - typedef vaddr_t = logic [AW-1:0] for the default AW
  - reused by the operand mux and execute stages
- Natural sub-module vreg_lane:
  - one lane's storage array (NREGS x WIDTH)
  - inputs: clk, rst, we gated by its wmask bit, wa, wd
  - two read ports with per-lane bypass
  - instantiated 4 times by vector_regfile, which contains only the lane instances and port wiring

Test Plan:
- Reset clear: preload r3 = {1,2,3,4}; assert rst one cycle; read ra1=3 -> rd11..rd14 = 0,0,0,0.
- Full write then read:
  - Stimulus: we=1, wa=5, wmask=4'b1111, wd = 32'hA0..A3; next cycle ra1=5, ra2=5.
  - Required: rd11..14 = rd21..24 = A0, A1, A2, A3.
- Masked write:
  - Stimulus: r5 holds A0..A3; write wa=5, wmask=4'b0101, wd = B0..B3.
  - Required: reading r5 gives B0, A1, B2, A3.
- Bypass:
  - Stimulus: in one cycle we=1, wa=7, wmask=4'b1111, wd = C0..C3, ra1=7, ra2=6 (r7 previously 0).
  - Required in the same cycle: rd11..14 = C0..C3 and rd21..24 = r6 contents.
  - Masked variant wmask=4'b0010 -> rd11..14 = 0, C1, 0, 0.
- Reset priority: rst=1 and we=1 (wa=2, wd=D0..D3) in the same cycle -> r2 = 0 afterwards; rd outputs show no bypass during the rst cycle.
- Dual-port independence: write r1 = {1,1,1,1} and r15 = {F,F,F,F}; ra1=1, ra2=15 -> port 1 = all 1, port 2 = all F.
  - Also sweep all 16 addresses with write/readback of value = address*0x01010101 + lane.
